// File: rtl/pair_sched.sv
// Pairwise scheduler: buffers a full point set from a valid/ready stream, then
// streams every unordered pair (i<j) to the distance pipeline with backpressure.
module pair_sched #(
   parameter int NUM_POINTS = 1000,
   parameter int DIM_W      = 17,
   localparam int IDX_W     = $clog2(NUM_POINTS),
   localparam int CNT_W     = $clog2(NUM_POINTS * (NUM_POINTS - 1) / 2 + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIM_W-1:0] xloc,
   input  logic [DIM_W-1:0] yloc,
   input  logic [DIM_W-1:0] zloc,
   input  logic             loc_vld,
   output logic             loc_rdy,
   output logic [DIM_W-1:0] pa_x,
   output logic [DIM_W-1:0] pa_y,
   output logic [DIM_W-1:0] pa_z,
   output logic [DIM_W-1:0] pb_x,
   output logic [DIM_W-1:0] pb_y,
   output logic [DIM_W-1:0] pb_z,
   output logic [IDX_W-1:0] pointa,
   output logic [IDX_W-1:0] pointb,
   output logic             pair_vld,
   input  logic             pair_rdy,
   output logic [CNT_W-1:0] pair_cnt,
   output logic             sched_done,
   output logic             busy
);

   if (NUM_POINTS < 2) begin : g_bad_num_points
      $error("pair_sched: NUM_POINTS must be >= 2");
   end

   localparam int PW = 3 * DIM_W;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_POINTS - 1);
   localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(NUM_POINTS - 2);

   typedef enum logic [1:0] {LOAD, PAIR, DONE} state_t;

   state_t           state;
   logic [PW-1:0]    store [NUM_POINTS];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] idx_i;
   logic [IDX_W-1:0] idx_j;
   logic             issue_done;
   logic             load_fire;
   logic             pair_fire;
   logic             issue;
   logic             last_out;
   logic [PW-1:0]    rd_a;
   logic [PW-1:0]    rd_b;

   assign load_fire = loc_vld && loc_rdy;
   assign pair_fire = pair_vld && pair_rdy;
   // The output registers double as the store read registers: a new read is
   // issued only when the current output slot is empty or being consumed.
   assign issue     = (state == PAIR) && !issue_done && (!pair_vld || pair_rdy);
   assign last_out  = (pointa == PENULT_IDX) && (pointb == LAST_IDX);
   assign rd_a      = store[idx_i];
   assign rd_b      = store[idx_j];

   always_ff @(posedge clk) begin
      if (load_fire) begin
         store[wr_idx] <= {xloc, yloc, zloc};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= LOAD;
         wr_idx     <= '0;
         idx_i      <= '0;
         idx_j      <= IDX_W'(1);
         issue_done <= 1'b0;
         loc_rdy    <= 1'b1;
         pair_vld   <= 1'b0;
         sched_done <= 1'b0;
         pair_cnt   <= '0;
         busy       <= 1'b0;
         pa_x       <= '0;
         pa_y       <= '0;
         pa_z       <= '0;
         pb_x       <= '0;
         pb_y       <= '0;
         pb_z       <= '0;
         pointa     <= '0;
         pointb     <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (load_fire) begin
                  busy <= 1'b1;
                  if (wr_idx == LAST_IDX) begin
                     state      <= PAIR;
                     wr_idx     <= '0;
                     loc_rdy    <= 1'b0;
                     idx_i      <= '0;
                     idx_j      <= IDX_W'(1);
                     issue_done <= 1'b0;
                  end else begin
                     wr_idx <= wr_idx + IDX_W'(1);
                  end
               end
            end

            PAIR: begin
               if (pair_fire) begin
                  pair_cnt <= pair_cnt + CNT_W'(1);
               end
               if (issue) begin
                  pa_x     <= rd_a[PW-1 -: DIM_W];
                  pa_y     <= rd_a[2*DIM_W-1 -: DIM_W];
                  pa_z     <= rd_a[DIM_W-1:0];
                  pb_x     <= rd_b[PW-1 -: DIM_W];
                  pb_y     <= rd_b[2*DIM_W-1 -: DIM_W];
                  pb_z     <= rd_b[DIM_W-1:0];
                  pointa   <= idx_i;
                  pointb   <= idx_j;
                  pair_vld <= 1'b1;
                  if ((idx_i == PENULT_IDX) && (idx_j == LAST_IDX)) begin
                     issue_done <= 1'b1;
                  end else if (idx_j == LAST_IDX) begin
                     idx_i <= idx_i + IDX_W'(1);
                     idx_j <= idx_i + IDX_W'(2);
                  end else begin
                     idx_j <= idx_j + IDX_W'(1);
                  end
               end else if (pair_fire) begin
                  pair_vld <= 1'b0;
                  if (last_out) begin
                     state      <= DONE;
                     sched_done <= 1'b1;
                  end
               end
            end

            DONE: begin
               state      <= LOAD;
               sched_done <= 1'b0;
               pair_cnt   <= '0;
               loc_rdy    <= 1'b1;
               busy       <= 1'b0;
               idx_i      <= '0;
               idx_j      <= IDX_W'(1);
            end

            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pair_sched.sv
// Directed bench for pair_sched: N=4 sequencing, backpressure, load gaps,
// mid-run reset, back-to-back runs, plus N=2 and N=200 instances.
module tb_pair_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   // N=4 instance
   logic [16:0] a_x, a_y, a_z, a_pax, a_pay, a_paz, a_pbx, a_pby, a_pbz;
   logic        a_vld, a_lrdy, a_pvld, a_prdy, a_done, a_busy;
   logic [1:0]  a_pa, a_pb;
   logic [2:0]  a_cnt;

   // N=2 instance
   logic [16:0] b_x, b_y, b_z, b_pax, b_pay, b_paz, b_pbx, b_pby, b_pbz;
   logic        b_vld, b_lrdy, b_pvld, b_prdy, b_done, b_busy;
   logic [0:0]  b_pa, b_pb;
   logic [0:0]  b_cnt;

   // N=200 instance
   logic [16:0] c_x, c_y, c_z, c_pax, c_pay, c_paz, c_pbx, c_pby, c_pbz;
   logic        c_vld, c_lrdy, c_pvld, c_prdy, c_done, c_busy;
   logic [7:0]  c_pa, c_pb;
   logic [14:0] c_cnt;

   pair_sched #(.NUM_POINTS(4), .DIM_W(17)) u_a (
      .clk(clk), .rst_n(rst_n), .xloc(a_x), .yloc(a_y), .zloc(a_z),
      .loc_vld(a_vld), .loc_rdy(a_lrdy),
      .pa_x(a_pax), .pa_y(a_pay), .pa_z(a_paz),
      .pb_x(a_pbx), .pb_y(a_pby), .pb_z(a_pbz),
      .pointa(a_pa), .pointb(a_pb), .pair_vld(a_pvld), .pair_rdy(a_prdy),
      .pair_cnt(a_cnt), .sched_done(a_done), .busy(a_busy)
   );

   pair_sched #(.NUM_POINTS(2), .DIM_W(17)) u_b (
      .clk(clk), .rst_n(rst_n), .xloc(b_x), .yloc(b_y), .zloc(b_z),
      .loc_vld(b_vld), .loc_rdy(b_lrdy),
      .pa_x(b_pax), .pa_y(b_pay), .pa_z(b_paz),
      .pb_x(b_pbx), .pb_y(b_pby), .pb_z(b_pbz),
      .pointa(b_pa), .pointb(b_pb), .pair_vld(b_pvld), .pair_rdy(b_prdy),
      .pair_cnt(b_cnt), .sched_done(b_done), .busy(b_busy)
   );

   pair_sched #(.NUM_POINTS(200), .DIM_W(17)) u_c (
      .clk(clk), .rst_n(rst_n), .xloc(c_x), .yloc(c_y), .zloc(c_z),
      .loc_vld(c_vld), .loc_rdy(c_lrdy),
      .pa_x(c_pax), .pa_y(c_pay), .pa_z(c_paz),
      .pb_x(c_pbx), .pb_y(c_pby), .pb_z(c_pbz),
      .pointa(c_pa), .pointb(c_pb), .pair_vld(c_pvld), .pair_rdy(c_prdy),
      .pair_cnt(c_cnt), .sched_done(c_done), .busy(c_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input int off, input bit gaps);
      int k = 0;
      int budget = 0;
      while (k < 4 && budget < 100) begin
         a_vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         a_x   = 17'(10 * k + off);
         a_y   = 17'(20 * k + off);
         a_z   = 17'(30 * k + off);
         chk("a_load_lrdy", 32'(a_lrdy), 1);
         chk("a_load_pvld", 32'(a_pvld), 0);
         chk("a_load_busy", 32'(a_busy), (k > 0) ? 1 : 0);
         tick;
         if (a_vld) k++;
         budget++;
      end
      chk("a_load_count", k, 4);
   endtask

   task automatic run_a(input int off, input bit toggle, input int stop_n);
      int exp_i[6];
      int exp_j[6];
      int n = 0;
      int idx = 0;
      int cyc = 0;
      bit rdy;
      bit pend = 1'b0;
      for (int p = 0; p < 3; p++) begin
         for (int q = p + 1; q < 4; q++) begin
            exp_i[n] = p;
            exp_j[n] = q;
            n++;
         end
      end
      chk("a_gap_pvld", 32'(a_pvld), 0);
      chk("a_gap_lrdy", 32'(a_lrdy), 0);
      tick;
      while (idx < stop_n && cyc < 60) begin
         rdy    = toggle ? (cyc % 3 == 0) : 1'b1;
         a_prdy = rdy;
         chk("a_run_lrdy", 32'(a_lrdy), 0);
         chk("a_run_cnt", 32'(a_cnt), idx);
         if (!toggle || pend) chk("a_run_pvld", 32'(a_pvld), 1);
         if (a_pvld) begin
            chk("a_pointa", 32'(a_pa), exp_i[idx]);
            chk("a_pointb", 32'(a_pb), exp_j[idx]);
            chk("a_pa_x", 32'(a_pax), 10 * exp_i[idx] + off);
            chk("a_pa_y", 32'(a_pay), 20 * exp_i[idx] + off);
            chk("a_pa_z", 32'(a_paz), 30 * exp_i[idx] + off);
            chk("a_pb_x", 32'(a_pbx), 10 * exp_j[idx] + off);
            chk("a_pb_y", 32'(a_pby), 20 * exp_j[idx] + off);
            chk("a_pb_z", 32'(a_pbz), 30 * exp_j[idx] + off);
            if (rdy) idx++;
         end
         pend = a_pvld && !rdy;
         tick;
         cyc++;
      end
      chk("a_pair_count", idx, stop_n);
      if (stop_n == 6) begin
         a_vld = 1'b0;
         chk("a_done_pulse", 32'(a_done), 1);
         chk("a_done_cnt", 32'(a_cnt), 6);
         chk("a_done_pvld", 32'(a_pvld), 0);
         chk("a_done_busy", 32'(a_busy), 1);
         chk("a_done_lrdy", 32'(a_lrdy), 0);
         tick;
         chk("a_post_done", 32'(a_done), 0);
         chk("a_post_lrdy", 32'(a_lrdy), 1);
         chk("a_post_cnt", 32'(a_cnt), 0);
         chk("a_post_busy", 32'(a_busy), 0);
         chk("a_post_pvld", 32'(a_pvld), 0);
      end
   endtask

   initial begin
      int hs;
      int last_a;
      int last_b;
      int last_bx;
      int budget;

      rst_n = 1'b0;
      a_x = '0; a_y = '0; a_z = '0; a_vld = 1'b0; a_prdy = 1'b0;
      b_x = '0; b_y = '0; b_z = '0; b_vld = 1'b0; b_prdy = 1'b0;
      c_x = '0; c_y = '0; c_z = '0; c_vld = 1'b0; c_prdy = 1'b0;
      tick;
      tick;

      chk("rst_lrdy", 32'(a_lrdy), 1);
      chk("rst_pvld", 32'(a_pvld), 0);
      chk("rst_done", 32'(a_done), 0);
      chk("rst_cnt", 32'(a_cnt), 0);
      chk("rst_busy", 32'(a_busy), 0);
      chk("rst_pax", 32'(a_pax), 0);
      chk("rst_pbz", 32'(a_pbz), 0);
      chk("rst_pointb", 32'(a_pb), 0);
      chk("rst_b_lrdy", 32'(b_lrdy), 1);
      chk("rst_c_pvld", 32'(c_pvld), 0);
      rst_n = 1'b1;

      // basic run, then a back-to-back second point set
      load_a(0, 1'b0);
      a_vld = 1'b0;
      run_a(0, 1'b0, 6);
      load_a(1, 1'b0);
      a_vld = 1'b0;
      run_a(1, 1'b0, 6);

      // backpressure 1,0,0 pattern
      load_a(2, 1'b0);
      a_vld = 1'b0;
      run_a(2, 1'b1, 6);

      // gappy load, loc_vld held high with junk during PAIR
      load_a(3, 1'b1);
      a_vld = 1'b1;
      a_x = 17'h1ABCD; a_y = 17'h0BEEF; a_z = 17'h1F00D;
      run_a(3, 1'b0, 6);

      // reset after three handshakes, then a fresh run
      load_a(4, 1'b0);
      a_vld = 1'b0;
      run_a(4, 1'b0, 3);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("mid_rst_lrdy", 32'(a_lrdy), 1);
      chk("mid_rst_pvld", 32'(a_pvld), 0);
      chk("mid_rst_cnt", 32'(a_cnt), 0);
      chk("mid_rst_done", 32'(a_done), 0);
      load_a(5, 1'b0);
      a_vld = 1'b0;
      run_a(5, 1'b0, 6);

      // N=2 corner
      b_prdy = 1'b1;
      b_vld  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         b_x = 17'(7 + k); b_y = 17'(100 + k); b_z = 17'(200 + k);
         chk("b_load_lrdy", 32'(b_lrdy), 1);
         tick;
      end
      b_vld = 1'b0;
      chk("b_gap_pvld", 32'(b_pvld), 0);
      tick;
      chk("b_pvld", 32'(b_pvld), 1);
      chk("b_pointa", 32'(b_pa), 0);
      chk("b_pointb", 32'(b_pb), 1);
      chk("b_pa_x", 32'(b_pax), 7);
      chk("b_pb_y", 32'(b_pby), 101);
      chk("b_pb_z", 32'(b_pbz), 201);
      tick;
      chk("b_done", 32'(b_done), 1);
      chk("b_done_cnt", 32'(b_cnt), 1);
      chk("b_done_pvld", 32'(b_pvld), 0);
      tick;
      chk("b_post_done", 32'(b_done), 0);
      chk("b_post_cnt", 32'(b_cnt), 0);
      chk("b_post_lrdy", 32'(b_lrdy), 1);

      // N=200 full-rate run
      c_prdy = 1'b1;
      c_vld  = 1'b1;
      for (int k = 0; k < 200; k++) begin
         c_x = 17'(k); c_y = 17'(k + 500); c_z = 17'(3 * k);
         tick;
      end
      c_vld   = 1'b0;
      hs      = 0;
      last_a  = -1;
      last_b  = -1;
      last_bx = -1;
      budget  = 0;
      while (!c_done && budget < 25000) begin
         if (c_pvld && c_prdy) begin
            hs++;
            last_a  = int'(c_pa);
            last_b  = int'(c_pb);
            last_bx = int'(c_pbx);
         end
         tick;
         budget++;
      end
      chk("c_done_seen", 32'(c_done), 1);
      chk("c_handshakes", hs, 19900);
      chk("c_done_cnt", 32'(c_cnt), 19900);
      chk("c_last_pointa", last_a, 198);
      chk("c_last_pointb", last_b, 199);
      chk("c_last_pb_x", last_bx, 199);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
